// File: rtl/pd_pwr_seq_ctrl_if.sv
// Regfile-control and domain-control bundle for one switchable power domain.
// The master side is the regfile/wakeup logic; the slave side is the sequencer.
interface pd_pwr_seq_ctrl_if #(
  parameter int M = 3
);
  logic         rf_o_sleep_req;
  logic [M-1:0] rf_o_wakeup_enable;
  logic         rf_o_pwrgate_enable;
  logic [3:0]   rf_o_pwr_on_seq_delay;
  logic [3:0]   rf_o_pwr_off_seq_delay;
  logic [7:0]   rf_o_pwr_on_delay;
  logic [7:0]   rf_o_pwr_off_delay;
  logic [M-1:0] i_wakeup_src;
  logic         o_clk_en;
  logic         o_iso;
  logic         o_ret;
  logic         o_rstn;
  logic         o_dcdc_enable;
  logic         fsm_o_d_status;
  logic         o_busy;

  modport master (
    output rf_o_sleep_req, rf_o_wakeup_enable, rf_o_pwrgate_enable,
           rf_o_pwr_on_seq_delay, rf_o_pwr_off_seq_delay,
           rf_o_pwr_on_delay, rf_o_pwr_off_delay, i_wakeup_src,
    input  o_clk_en, o_iso, o_ret, o_rstn, o_dcdc_enable, fsm_o_d_status, o_busy
  );

  modport slave (
    input  rf_o_sleep_req, rf_o_wakeup_enable, rf_o_pwrgate_enable,
           rf_o_pwr_on_seq_delay, rf_o_pwr_off_seq_delay,
           rf_o_pwr_on_delay, rf_o_pwr_off_delay, i_wakeup_src,
    output o_clk_en, o_iso, o_ret, o_rstn, o_dcdc_enable, fsm_o_d_status, o_busy
  );
endinterface

// File: rtl/pd_pwr_seq_ctrl.sv
// Power-sequencing FSM for one switchable power domain, clocked in the always-on domain.
// Steps clock-enable, isolation, retention, reset and DCDC enable in a fixed, timed order.
module pd_pwr_seq_ctrl #(
  parameter int M = 3
) (
  input logic              i_aon_clk,
  input logic              i_soc_pwr_on_rst,
  pd_pwr_seq_ctrl_if.slave pd
);

  typedef enum logic [3:0] {
    ACTIVE, OFF_CLK, OFF_ISO, OFF_RET, OFF_RST, OFF_DCDC, SLEEP,
    ON_DCDC, ON_RET, ON_RST, ON_ISO, ON_CLK, CG_CLK, CG_SLEEP, CG_WAKE
  } state_e;

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         arm_q, arm_d;
  logic [3:0]   offSeqDly_q, offSeqDly_d;
  logic [3:0]   onSeqDly_q, onSeqDly_d;
  logic [7:0]   pwrOffDly_q, pwrOffDly_d;
  logic         clkEn_q, clkEn_d;
  logic         iso_q, iso_d;
  logic         ret_q, ret_d;
  logic         rstn_q, rstn_d;
  logic         dcdc_q, dcdc_d;
  logic         status_q, status_d;
  logic         busy_q, busy_d;
  logic [M-1:0] wakeSrc;
  logic         wake;
  logic         cntDone;

  assign wakeSrc = pd.i_wakeup_src & pd.rf_o_wakeup_enable;
  assign wake    = |wakeSrc;
  assign cntDone = (cnt_q == 8'd0);

  // A timed state is entered with cnt loaded to its delay and left on the cycle cnt reads zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cntDone ? 8'd0 : cnt_q - 8'd1;
    arm_d       = arm_q;
    offSeqDly_d = offSeqDly_q;
    onSeqDly_d  = onSeqDly_q;
    pwrOffDly_d = pwrOffDly_q;
    clkEn_d     = clkEn_q;
    iso_d       = iso_q;
    ret_d       = ret_q;
    rstn_d      = rstn_q;
    dcdc_d      = dcdc_q;
    status_d    = status_q;
    busy_d      = busy_q;

    if (!pd.rf_o_sleep_req) arm_d = 1'b1;

    case (state_q)
      ACTIVE: begin
        if (pd.rf_o_sleep_req && arm_q && !wake) begin
          // Delays are captured here so regfile writes only affect the next sequence.
          offSeqDly_d = pd.rf_o_pwr_off_seq_delay;
          pwrOffDly_d = pd.rf_o_pwr_off_delay;
          arm_d       = 1'b0;
          clkEn_d     = 1'b0;
          status_d    = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = {4'd0, pd.rf_o_pwr_off_seq_delay};
          state_d     = pd.rf_o_pwrgate_enable ? OFF_CLK : CG_CLK;
        end
      end
      OFF_CLK: if (cntDone) begin
        iso_d   = 1'b1;
        cnt_d   = {4'd0, offSeqDly_q};
        state_d = OFF_ISO;
      end
      OFF_ISO: if (cntDone) begin
        ret_d   = 1'b1;
        cnt_d   = {4'd0, offSeqDly_q};
        state_d = OFF_RET;
      end
      OFF_RET: if (cntDone) begin
        rstn_d  = 1'b0;
        cnt_d   = pwrOffDly_q;
        state_d = OFF_RST;
      end
      OFF_RST: if (cntDone) begin
        dcdc_d  = 1'b0;
        cnt_d   = 8'd0;
        state_d = OFF_DCDC;
      end
      OFF_DCDC: begin
        busy_d  = 1'b0;
        state_d = SLEEP;
      end
      SLEEP: begin
        if (wake) begin
          onSeqDly_d = pd.rf_o_pwr_on_seq_delay;
          dcdc_d     = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = pd.rf_o_pwr_on_delay;
          state_d    = ON_DCDC;
        end
      end
      ON_DCDC: if (cntDone) begin
        ret_d   = 1'b0;
        cnt_d   = {4'd0, onSeqDly_q};
        state_d = ON_RET;
      end
      ON_RET: if (cntDone) begin
        rstn_d  = 1'b1;
        cnt_d   = {4'd0, onSeqDly_q};
        state_d = ON_RST;
      end
      ON_RST: if (cntDone) begin
        iso_d   = 1'b0;
        cnt_d   = {4'd0, onSeqDly_q};
        state_d = ON_ISO;
      end
      ON_ISO: if (cntDone) begin
        clkEn_d = 1'b1;
        cnt_d   = 8'd0;
        state_d = ON_CLK;
      end
      ON_CLK: begin
        status_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ACTIVE;
      end
      CG_CLK: if (cntDone) begin
        busy_d  = 1'b0;
        state_d = CG_SLEEP;
      end
      CG_SLEEP: begin
        if (wake) begin
          onSeqDly_d = pd.rf_o_pwr_on_seq_delay;
          busy_d     = 1'b1;
          cnt_d      = {4'd0, pd.rf_o_pwr_on_seq_delay};
          state_d    = CG_WAKE;
        end
      end
      CG_WAKE: if (cntDone) begin
        clkEn_d  = 1'b1;
        status_d = 1'b1;
        busy_d   = 1'b0;
        state_d  = ACTIVE;
      end
      default: state_d = ACTIVE;
    endcase
  end

  always_ff @(posedge i_aon_clk) begin
    if (i_soc_pwr_on_rst) begin
      state_q     <= ACTIVE;
      cnt_q       <= 8'd0;
      arm_q       <= 1'b1;
      offSeqDly_q <= 4'd0;
      onSeqDly_q  <= 4'd0;
      pwrOffDly_q <= 8'd0;
      clkEn_q     <= 1'b1;
      iso_q       <= 1'b0;
      ret_q       <= 1'b0;
      rstn_q      <= 1'b1;
      dcdc_q      <= 1'b1;
      status_q    <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      arm_q       <= arm_d;
      offSeqDly_q <= offSeqDly_d;
      onSeqDly_q  <= onSeqDly_d;
      pwrOffDly_q <= pwrOffDly_d;
      clkEn_q     <= clkEn_d;
      iso_q       <= iso_d;
      ret_q       <= ret_d;
      rstn_q      <= rstn_d;
      dcdc_q      <= dcdc_d;
      status_q    <= status_d;
      busy_q      <= busy_d;
    end
  end

  assign pd.o_clk_en       = clkEn_q;
  assign pd.o_iso          = iso_q;
  assign pd.o_ret          = ret_q;
  assign pd.o_rstn         = rstn_q;
  assign pd.o_dcdc_enable  = dcdc_q;
  assign pd.fsm_o_d_status = status_q;
  assign pd.o_busy         = busy_q;

endmodule

// File: tb/tb_pd_pwr_seq_ctrl.sv
// Scoreboard bench for pd_pwr_seq_ctrl: every output-vector change is matched against a queued
// expectation carrying the cycle it must appear on. Vector = {clk_en,iso,ret,rstn,dcdc,status,busy}.
module tb_pd_pwr_seq_ctrl;
  localparam int M = 3;
  localparam logic [6:0] RST_VEC = 7'b1001110;

  typedef struct {
    string      name;
    int         cyc;
    logic [6:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  pd_pwr_seq_ctrl_if #(.M(M)) pdIf ();

  pd_pwr_seq_ctrl #(.M(M)) dut (
    .i_aon_clk       (clk),
    .i_soc_pwr_on_rst(rst),
    .pd              (pdIf)
  );

  always #5 clk = ~clk;

  task automatic pushExp(input string name, input int c, input logic [6:0] v);
    exp_t e;
    e.name = name;
    e.cyc  = c;
    e.vec  = v;
    expQ.push_back(e);
  endtask

  // Drives a full regfile/wakeup configuration on the falling edge.
  task automatic applyStimulus(input logic sleepReq, input logic pwrgate,
                               input logic [2:0] en, input logic [2:0] src,
                               input logic [3:0] offSeq, input logic [3:0] onSeq,
                               input logic [7:0] pwrOff, input logic [7:0] pwrOn);
    @(negedge clk);
    pdIf.rf_o_sleep_req         = sleepReq;
    pdIf.rf_o_pwrgate_enable    = pwrgate;
    pdIf.rf_o_wakeup_enable     = en;
    pdIf.i_wakeup_src           = src;
    pdIf.rf_o_pwr_off_seq_delay = offSeq;
    pdIf.rf_o_pwr_on_seq_delay  = onSeq;
    pdIf.rf_o_pwr_off_delay     = pwrOff;
    pdIf.rf_o_pwr_on_delay      = pwrOn;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while (expQ.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout pending=%0d required=0 next=%s", expQ.size(), expQ[0].name);
      expQ.delete();
    end
  endtask

  task automatic checkOutput(input logic [6:0] v);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_change cycle=%0d got=%b required=no_change", cyc, v);
    end else begin
      e = expQ.pop_front();
      if (e.vec !== v || e.cyc != cyc) begin
        errors++;
        $display("[TB] FAIL %s got=%b@%0d required=%b@%0d", e.name, v, cyc, e.vec, e.cyc);
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge, checks invariants and vector changes.
  initial begin
    logic [6:0] prevVec;
    logic [6:0] curVec;
    prevVec = 'x;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      curVec = {pdIf.o_clk_en, pdIf.o_iso, pdIf.o_ret, pdIf.o_rstn,
                pdIf.o_dcdc_enable, pdIf.fsm_o_d_status, pdIf.o_busy};
      checks++;
      if (((!curVec[2] || !curVec[3]) && !curVec[5]) || (curVec[5] && curVec[6])) begin
        errors++;
        $display("[TB] FAIL invariant cycle=%0d got=%b required=iso_when_off_and_no_clk_when_iso", cyc, curVec);
      end
      if (curVec !== prevVec) checkOutput(curVec);
      prevVec = curVec;
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    pdIf.rf_o_sleep_req         = 1'b0;
    pdIf.rf_o_pwrgate_enable    = 1'b1;
    pdIf.rf_o_wakeup_enable     = 3'b000;
    pdIf.i_wakeup_src           = 3'b000;
    pdIf.rf_o_pwr_off_seq_delay = 4'd0;
    pdIf.rf_o_pwr_on_seq_delay  = 4'd0;
    pdIf.rf_o_pwr_off_delay     = 8'd0;
    pdIf.rf_o_pwr_on_delay      = 8'd0;
    pushExp("reset_values", 1, RST_VEC);
    waitCycles(3);
    rst = 1'b0;
    waitDrain(5);

    $display("[TB] power-gate off sequence, all delays zero");
    applyStimulus(1, 1, 3'b111, 3'b000, 0, 0, 0, 0);
    t = cyc;
    pushExp("t1_clk_off", t + 1, 7'b0001101);
    pushExp("t1_iso_on",  t + 2, 7'b0101101);
    pushExp("t1_ret_on",  t + 3, 7'b0111101);
    pushExp("t1_rst_on",  t + 4, 7'b0110101);
    pushExp("t1_dcdc_off", t + 5, 7'b0110001);
    pushExp("t1_sleep",   t + 6, 7'b0110000);
    waitDrain(20);
    waitCycles(3);
    applyStimulus(1, 1, 3'b111, 3'b001, 0, 0, 0, 0);
    t = cyc;
    pushExp("t1_dcdc_on", t + 1, 7'b0110101);
    pushExp("t1_restore", t + 2, 7'b0100101);
    pushExp("t1_rst_off", t + 3, 7'b0101101);
    pushExp("t1_iso_off", t + 4, 7'b0001101);
    pushExp("t1_clk_on",  t + 5, 7'b1001101);
    pushExp("t1_active",  t + 6, 7'b1001110);
    waitDrain(20);

    $display("[TB] sleep_req held through wakeup keeps domain active");
    applyStimulus(1, 1, 3'b111, 3'b000, 0, 0, 0, 0);
    waitCycles(8);

    $display("[TB] timed off sequence, delays rewritten mid-sequence");
    applyStimulus(0, 1, 3'b111, 3'b000, 3, 1, 10, 5);
    applyStimulus(1, 1, 3'b111, 3'b000, 3, 1, 10, 5);
    t = cyc;
    pushExp("t2_clk_off",  t + 1,  7'b0001101);
    pushExp("t2_iso_on",   t + 5,  7'b0101101);
    pushExp("t2_ret_on",   t + 9,  7'b0111101);
    pushExp("t2_rst_on",   t + 13, 7'b0110101);
    pushExp("t2_dcdc_off", t + 24, 7'b0110001);
    pushExp("t2_sleep",    t + 25, 7'b0110000);
    waitCycles(2);
    applyStimulus(1, 1, 3'b111, 3'b000, 0, 1, 1, 5);
    waitDrain(40);

    $display("[TB] wakeup masking and timed power-on");
    applyStimulus(1, 1, 3'b001, 3'b010, 0, 1, 1, 5);
    waitCycles(6);
    applyStimulus(1, 1, 3'b010, 3'b010, 0, 1, 1, 5);
    t = cyc;
    pushExp("t3_dcdc_on", t + 1,  7'b0110101);
    pushExp("t3_restore", t + 7,  7'b0100101);
    pushExp("t3_rst_off", t + 9,  7'b0101101);
    pushExp("t3_iso_off", t + 11, 7'b0001101);
    pushExp("t3_clk_on",  t + 13, 7'b1001101);
    pushExp("t3_active",  t + 14, 7'b1001110);
    waitCycles(1);
    applyStimulus(1, 1, 3'b010, 3'b010, 0, 3, 1, 0);
    waitDrain(30);
    applyStimulus(1, 1, 3'b010, 3'b000, 0, 1, 1, 5);

    $display("[TB] clock-gate-only sleep and wake");
    applyStimulus(0, 0, 3'b001, 3'b000, 2, 1, 1, 5);
    applyStimulus(1, 0, 3'b001, 3'b000, 2, 1, 1, 5);
    t = cyc;
    pushExp("t4_cg_clk_off", t + 1, 7'b0001101);
    pushExp("t4_cg_sleep",   t + 4, 7'b0001100);
    waitDrain(20);
    waitCycles(2);
    applyStimulus(1, 0, 3'b001, 3'b001, 2, 1, 1, 5);
    t = cyc;
    pushExp("t4_cg_wake",   t + 1, 7'b0001101);
    pushExp("t4_cg_active", t + 3, 7'b1001110);
    waitDrain(20);

    $display("[TB] re-arm, sleep blocked by wake, then reset mid-sequence");
    applyStimulus(1, 0, 3'b001, 3'b000, 2, 1, 1, 5);
    waitCycles(8);
    applyStimulus(0, 1, 3'b001, 3'b001, 1, 1, 3, 2);
    applyStimulus(1, 1, 3'b001, 3'b001, 1, 1, 3, 2);
    waitCycles(6);
    applyStimulus(1, 1, 3'b001, 3'b000, 1, 1, 3, 2);
    t = cyc;
    pushExp("t6_clk_off", t + 1, 7'b0001101);
    pushExp("t6_iso_on",  t + 3, 7'b0101101);
    pushExp("t6_ret_on",  t + 5, 7'b0111101);
    waitDrain(20);
    rst = 1'b1;
    pdIf.rf_o_sleep_req         = 1'b0;
    pdIf.rf_o_pwr_off_seq_delay = 4'd9;
    pdIf.rf_o_pwr_off_delay     = 8'd40;
    pushExp("t6_reset_abort", cyc + 1, RST_VEC);
    waitCycles(3);
    rst = 1'b0;
    pdIf.rf_o_sleep_req         = 1'b1;
    pdIf.rf_o_pwrgate_enable    = 1'b0;
    pdIf.rf_o_pwr_off_seq_delay = 4'd0;
    t = cyc;
    pushExp("t6_armed_after_reset", t + 1, 7'b0001101);
    pushExp("t6_cg_sleep",          t + 2, 7'b0001100);
    waitDrain(20);
    waitCycles(3);

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover_expectations got=%0d required=0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running required=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
